// File: rtl/perf_counter_unit.sv
// -----------------------------------------------------------------------------
// perf_counter_unit
//
// Purpose:
//   Five saturating performance counters, plus a background sequential divider.
//   The counters track enabled cycles, stalls, arithmetic retires, memory
//   retires and total retires. The divider keeps cpi refreshed with
//   cycle_count / instruction_count.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   en                counting enable (the divider keeps running when low)
//   clear             synchronous clear of counters, cpi and the divider
//   stall_evt         stall event this cycle
//   arith_evt         arithmetic instruction retired this cycle
//   mem_evt           memory instruction retired this cycle
//   instr_retire      any instruction retired this cycle
//   stall_count       saturating stall count
//   aritmetric_count  saturating arithmetic count
//   memory_count      saturating memory count
//   instruction_count saturating retired-instruction count
//   cycle_count       saturating enabled-cycle count
//   cpi               last completed quotient cycle_count / instruction_count
//   cpi_valid         cpi holds a completed result
//   busy              divider is in DIV or DONE
// -----------------------------------------------------------------------------
module perf_counter_unit #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             stall_evt,
    input  logic             arith_evt,
    input  logic             mem_evt,
    input  logic             instr_retire,
    output logic [WIDTH-1:0] stall_count,
    output logic [WIDTH-1:0] aritmetric_count,
    output logic [WIDTH-1:0] memory_count,
    output logic [WIDTH-1:0] instruction_count,
    output logic [WIDTH-1:0] cycle_count,
    output logic [WIDTH-1:0] cpi,
    output logic             cpi_valid,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH + 1);

    // Counter slots: 0 cycle, 1 stall, 2 arith, 3 mem, 4 instr.
    logic [4:0]       inc_vec;
    logic [WIDTH-1:0] cnt_q [5];

    assign inc_vec = {instr_retire, mem_evt, arith_evt, stall_evt, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cnt
            logic [WIDTH-1:0] val_q;
            logic [WIDTH-1:0] val_d;

            always_comb begin
                val_d = val_q;
                if (clear) begin
                    val_d = '0;
                end else if (en && inc_vec[gi] && (val_q != {WIDTH{1'b1}})) begin
                    // Stop at all-ones rather than wrapping.
                    val_d = val_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) val_q <= '0;
                else     val_q <= val_d;
            end

            assign cnt_q[gi] = val_q;
        end
    endgenerate

    assign cycle_count       = cnt_q[0];
    assign stall_count       = cnt_q[1];
    assign aritmetric_count  = cnt_q[2];
    assign memory_count      = cnt_q[3];
    assign instruction_count = cnt_q[4];

    // ---------------------------------------------------------------------
    // Restoring divider. quo_q starts as the dividend snapshot. Each DIV
    // edge shifts one dividend bit into the partial remainder and one
    // quotient bit into the bottom of quo_q.
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [WIDTH-1:0] cpi_q, cpi_d;
    logic             valid_q, valid_d;

    // The partial remainder is always below the divisor, so one extra bit
    // is enough to hold the shifted value.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;
    logic           rem_ge;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        iter_d  = iter_q;
        cpi_d   = cpi_q;
        valid_d = valid_q;

        if (clear) begin
            state_d = IDLE;
            quo_d   = '0;
            rem_d   = '0;
            dvs_d   = '0;
            iter_d  = '0;
            cpi_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Snapshot the pre-edge counters. Later counting cannot disturb this division.
                    if (instruction_count != '0) begin
                        quo_d   = cycle_count;
                        rem_d   = '0;
                        dvs_d   = instruction_count;
                        iter_d  = IW'(WIDTH);
                        state_d = DIV;
                    end
                end
                DIV: begin
                    quo_d  = {quo_q[WIDTH-2:0], rem_ge};
                    rem_d  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    iter_d = iter_q - IW'(1);
                    if (iter_q == IW'(1)) state_d = DONE;
                end
                DONE: begin
                    cpi_d   = quo_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            iter_q  <= '0;
            cpi_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            iter_q  <= iter_d;
            cpi_q   <= cpi_d;
            valid_q <= valid_d;
        end
    end

    assign cpi       = cpi_q;
    assign cpi_valid = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_perf_counter_unit.sv
module tb_perf_counter_unit;

    localparam int W  = 19;
    localparam int SW = 5;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, clear, stall_evt, arith_evt, mem_evt, instr_retire;
    logic [W-1:0] stall_count, aritmetric_count, memory_count;
    logic [W-1:0] instruction_count, cycle_count, cpi;
    logic cpi_valid, busy;

    // Narrow instance used only to reach saturation in a few cycles.
    logic s_rst, s_en, s_clear, s_stall, s_zero;
    logic [SW-1:0] s_stall_count, s_arith_count, s_mem_count;
    logic [SW-1:0] s_instr_count, s_cycle_count, s_cpi;
    logic s_cpi_valid, s_busy;

    perf_counter_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .stall_evt(stall_evt), .arith_evt(arith_evt), .mem_evt(mem_evt),
        .instr_retire(instr_retire),
        .stall_count(stall_count), .aritmetric_count(aritmetric_count),
        .memory_count(memory_count), .instruction_count(instruction_count),
        .cycle_count(cycle_count), .cpi(cpi), .cpi_valid(cpi_valid), .busy(busy)
    );

    perf_counter_unit #(.WIDTH(SW)) dut_small (
        .clk(clk), .rst(s_rst), .en(s_en), .clear(s_clear),
        .stall_evt(s_stall), .arith_evt(s_zero), .mem_evt(s_zero),
        .instr_retire(s_zero),
        .stall_count(s_stall_count), .aritmetric_count(s_arith_count),
        .memory_count(s_mem_count), .instruction_count(s_instr_count),
        .cycle_count(s_cycle_count), .cpi(s_cpi), .cpi_valid(s_cpi_valid), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: event tallies, plus a "result arrives W+1 edges after start" window.
    longint m_cnt [5];   // 0 cycle, 1 stall, 2 arith, 3 mem, 4 instr
    longint m_cpi;
    bit     m_valid;
    int     m_busy_left;
    longint m_snap_cyc, m_snap_ins;

    task automatic model_reset();
        for (int k = 0; k < 5; k++) m_cnt[k] = 0;
        m_cpi = 0; m_valid = 0; m_busy_left = 0; m_snap_cyc = 0; m_snap_ins = 0;
    endtask

    task automatic model_edge();
        bit evts [5];
        evts[0] = 1'b1; evts[1] = stall_evt; evts[2] = arith_evt;
        evts[3] = mem_evt; evts[4] = instr_retire;
        if (clear) begin
            model_reset();
        end else begin
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_cpi = m_snap_cyc / m_snap_ins;
                    m_valid = 1;
                end
            end else if (m_cnt[4] != 0) begin
                m_snap_cyc = m_cnt[0];
                m_snap_ins = m_cnt[4];
                m_busy_left = W + 1;
            end
            if (en) begin
                for (int k = 0; k < 5; k++)
                    if (evts[k] && m_cnt[k] < MAXV) m_cnt[k]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 0; clear = 0; stall_evt = 0; arith_evt = 0; mem_evt = 0; instr_retire = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        en = 1; stall_evt = 1; arith_evt = 1; mem_evt = 1; instr_retire = 1;
        for (int i = 0; i < 3; i++) step();
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if ({stall_count, aritmetric_count, memory_count, instruction_count,
             cycle_count, cpi, cpi_valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: got cyc=%0d ins=%0d cpi=%0d valid=%0b busy=%0b, expected all 0",
                     cycle_count, instruction_count, cpi, cpi_valid, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_edge();
        do_reset();
        en = 1;
        step();
        checks++;
        if (cycle_count !== W'(1)) begin
            errors++;
            $display("FAIL first_edge_cycle: got %0d expected 1", cycle_count);
        end
        checks++;
        if (instruction_count !== '0) begin
            errors++;
            $display("FAIL first_edge_instr: got %0d expected 0", instruction_count);
        end
        $display("test_first_edge done");
    endtask

    task automatic test_cpi();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            en = 1;
            instr_retire = ((i % 4) == 3);
            step();
            checks++;
            if (busy !== (m_busy_left > 0) || cpi !== W'(m_cpi) || cpi_valid !== m_valid) begin
                errors++;
                $display("FAIL cpi_run cycle %0d: got busy=%0b cpi=%0d valid=%0b expected busy=%0b cpi=%0d valid=%0b",
                         i, busy, cpi, cpi_valid, (m_busy_left > 0), m_cpi, m_valid);
            end
        end
        idle_inputs();
        checks++;
        if (instruction_count !== W'(25) || cycle_count !== W'(100)) begin
            errors++;
            $display("FAIL cpi_counts: got ins=%0d cyc=%0d expected ins=25 cyc=100",
                     instruction_count, cycle_count);
        end
        for (int i = 0; i < 60; i++) step();
        checks++;
        if (cpi !== W'(4) || cpi_valid !== 1'b1) begin
            errors++;
            $display("FAIL cpi_result: got cpi=%0d valid=%0b expected cpi=4 valid=1", cpi, cpi_valid);
        end
        $display("test_cpi done cpi=%0d", cpi);
    endtask

    task automatic test_no_instr();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            en = 1;
            stall_evt = 1'($urandom);
            arith_evt = 1'($urandom);
            mem_evt = 1'($urandom);
            instr_retire = 0;
            step();
            checks++;
            if (busy !== 1'b0 || cpi !== '0 || cpi_valid !== 1'b0) begin
                errors++;
                $display("FAIL no_instr cycle %0d: got busy=%0b cpi=%0d valid=%0b expected 0 0 0",
                         i, busy, cpi, cpi_valid);
            end
        end
        $display("test_no_instr done");
    endtask

    task automatic test_events();
        do_reset();
        en = 1; stall_evt = 1; arith_evt = 1; mem_evt = 1;
        for (int i = 0; i < 7; i++) step();
        idle_inputs();
        step();
        checks++;
        if (stall_count !== W'(7) || aritmetric_count !== W'(7) || memory_count !== W'(7)) begin
            errors++;
            $display("FAIL events: got stall=%0d arith=%0d mem=%0d expected 7 7 7",
                     stall_count, aritmetric_count, memory_count);
        end
        $display("test_events done");
    endtask

    task automatic test_saturation();
        int exp_v;
        s_rst = 1; s_en = 0; s_clear = 0; s_stall = 0;
        @(negedge clk);
        @(negedge clk);
        s_rst = 0; s_en = 1; s_stall = 1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = (i < (1 << SW) - 1) ? i : (1 << SW) - 1;
            checks++;
            if (s_cycle_count !== SW'(exp_v) || s_stall_count !== SW'(exp_v)) begin
                errors++;
                $display("FAIL saturation step %0d: got cyc=%0d stall=%0d expected %0d",
                         i, s_cycle_count, s_stall_count, exp_v);
            end
        end
        s_en = 0; s_stall = 0;
        $display("test_saturation done");
    endtask

    task automatic test_reset_mid_div();
        bool_found: begin end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            en = 1;
            instr_retire = ((i % 2) == 1);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 60; i++) begin
            if (m_busy_left == W + 1 - 5) break;
            step();
        end
        checks++;
        if (busy !== 1'b1 || cpi_valid !== 1'b1 || m_busy_left != W + 1 - 5) begin
            errors++;
            $display("FAIL mid_div_setup: got busy=%0b valid=%0b left=%0d expected busy=1 valid=1 left=%0d",
                     busy, cpi_valid, m_busy_left, W + 1 - 5);
        end
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if (busy !== 1'b0 || cpi !== '0 || cpi_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_div_reset: got busy=%0b cpi=%0d valid=%0b expected 0 0 0", busy, cpi, cpi_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < W + 5; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || cpi !== '0 || cpi_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_div_late cycle %0d: got busy=%0b cpi=%0d valid=%0b expected 0 0 0",
                         i, busy, cpi, cpi_valid);
            end
        end
        $display("test_reset_mid_div done");
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            en = 1;
            stall_evt = 1'($urandom);
            arith_evt = 1'($urandom);
            mem_evt = 1'($urandom);
            instr_retire = ((i % 2) == 0);
            step();
        end
        en = 1; clear = 1; stall_evt = 1; arith_evt = 1; mem_evt = 1; instr_retire = 1;
        step();
        idle_inputs();
        checks++;
        if ({stall_count, aritmetric_count, memory_count, instruction_count, cycle_count} !== '0) begin
            errors++;
            $display("FAIL clear_counters: got cyc=%0d stall=%0d arith=%0d mem=%0d ins=%0d expected all 0",
                     cycle_count, stall_count, aritmetric_count, memory_count, instruction_count);
        end
        checks++;
        if (cpi !== '0 || cpi_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_div: got cpi=%0d valid=%0b busy=%0b expected 0 0 0", cpi, cpi_valid, busy);
        end
        $display("test_clear done");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 3) != 0);
            stall_evt = 1'($urandom);
            arith_evt = 1'($urandom);
            mem_evt = 1'($urandom);
            instr_retire = ($urandom_range(0, 4) == 0);
            clear = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if (cycle_count !== W'(m_cnt[0]) || stall_count !== W'(m_cnt[1]) ||
                aritmetric_count !== W'(m_cnt[2]) || memory_count !== W'(m_cnt[3]) ||
                instruction_count !== W'(m_cnt[4])) begin
                errors++;
                $display("FAIL random_counts cycle %0d: got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                         i, cycle_count, stall_count, aritmetric_count, memory_count, instruction_count,
                         m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], m_cnt[4]);
            end
            checks++;
            if (busy !== (m_busy_left > 0) || cpi !== W'(m_cpi) || cpi_valid !== m_valid) begin
                errors++;
                $display("FAIL random_div cycle %0d: got busy=%0b cpi=%0d valid=%0b expected busy=%0b cpi=%0d valid=%0b",
                         i, busy, cpi, cpi_valid, (m_busy_left > 0), m_cpi, m_valid);
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        s_rst = 1; s_en = 0; s_clear = 0; s_stall = 0; s_zero = 0;
        model_reset();
        test_reset();
        test_first_edge();
        test_cpi();
        test_no_instr();
        test_events();
        test_saturation();
        test_reset_mid_div();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 19, which sets the width of every counter and of the CPI result.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port en, input, 1 bit: counting enable; when low, all counters SHALL freeze.
REQ-005 Port clear, input, 1 bit: synchronous clear of all counters and the divider.
REQ-006 Port stall_evt, input, 1 bit: pipeline stall event in this cycle.
REQ-007 Port arith_evt, input, 1 bit: an arithmetic instruction retired in this cycle.
REQ-008 Port mem_evt, input, 1 bit: a memory instruction retired in this cycle.
REQ-009 Port instr_retire, input, 1 bit: any instruction retired in this cycle.
REQ-010 Port stall_count, output, WIDTH bits: stall count, sent to the register file stall_count input.
REQ-011 Port aritmetric_count, output, WIDTH bits: arithmetic count, sent to the register file.
REQ-012 Port memory_count, output, WIDTH bits: memory count, sent to the register file.
REQ-013 Port instruction_count, output, WIDTH bits: retired instruction count, sent to the register file.
REQ-014 Port cycle_count, output, WIDTH bits: enabled-cycle count.
REQ-015 Port cpi, output, WIDTH bits: integer quotient cycle_count / instruction_count.
REQ-016 Port cpi_valid, output, 1 bit: cpi holds a completed division result.
REQ-017 Port busy, output, 1 bit: a division is in progress.

Function
REQ-018 When en=1 and clear=0, cycle_count SHALL increment by 1 on every edge, and each event counter SHALL increment by 1 on every edge where its event input is 1.
REQ-019 All five counters SHALL saturate at 2^WIDTH-1 and hold that value; they SHALL NOT wrap.
REQ-020 When en=0, counters SHALL hold their values while the divider continues to run.
REQ-021 clear=1 SHALL zero all counters, cpi and cpi_valid, abort any division and return the FSM to IDLE on that edge; clear SHALL take priority over en and all events.
REQ-022 Event inputs SHALL be counted independently; any combination of events in one cycle SHALL increment every asserted counter.
REQ-023 The FSM SHALL have the states IDLE, DIV and DONE.
REQ-024 IDLE->DIV SHALL occur on edge S when clear=0 and instruction_count!=0.
REQ-025 At edge S, the divider SHALL snapshot dividend=cycle_count and divisor=instruction_count, using the pre-edge register values, and load an iteration counter with WIDTH.
REQ-026 While in IDLE with instruction_count=0, the FSM SHALL stay in IDLE, and cpi and cpi_valid SHALL hold their values; no divide-by-zero is ever started.
REQ-027 DIV SHALL perform unsigned restoring division, one quotient bit per edge, MSB first, for exactly WIDTH edges, then move to DONE.
REQ-028 DONE->IDLE SHALL occur on edge S+WIDTH+1, loading cpi with the quotient and setting cpi_valid=1; the remainder SHALL be discarded.
REQ-029 busy SHALL be 1 exactly while the state is DIV or DONE.
REQ-030 The next division SHALL start no earlier than edge S+WIDTH+2, so results refresh continuously.
REQ-031 cpi SHALL hold its previous result during a division; cpi_valid, once set, SHALL stay 1 until reset or clear.
REQ-032 Counter changes after edge S SHALL NOT affect the division in flight.

Reset
REQ-033 rst=1 SHALL asynchronously force all counters, cpi, cpi_valid, busy, the quotient, remainder and iteration registers to 0, and the state to IDLE.
REQ-034 Reset during DIV or DONE SHALL discard the partial result; cpi SHALL read 0 with no late update.
REQ-035 On the first edge after rst deasserts with en=1, cycle_count SHALL become 1.

Verification
REQ-036 Reset, then en=1 for 100 cycles with instr_retire=1 every 4th cycle (25 pulses), then en=0 -> instruction_count=25, cycle_count=100, and the first division completing after en falls gives cpi=4 with cpi_valid=1.
REQ-037 Reset, then hold instruction_count=0 for 50 cycles -> busy=0, cpi=0, cpi_valid=0 throughout.
REQ-038 Assert stall_evt, arith_evt and mem_evt together for 7 enabled cycles -> stall_count=7, aritmetric_count=7, memory_count=7.
REQ-039 Preload cycle_count to 524286 (WIDTH=19) and enable for 5 cycles -> cycle_count=524287 and holds there.
REQ-040 Assert rst 5 cycles into a DIV -> busy=0 and cpi=0 immediately, with no cpi update on later edges; assert clear together with all events on one edge -> all counters read 0 after that edge.
